vga_timing_gen: RTL and testbench

- Raster timing generator that produces Hsync, Vsync and DE for the display path.
- Sits directly upstream of the BRAM address controller, which consumes Hsync/Vsync to build frame-buffer addresses.
- Also exports raw raster position and one-cycle line/frame markers so downstream fetch logic can align without re-deriving timing.
- Defaults are 640x480@60 with a 25 MHz pixel rate, advanced by a pixel-enable input.

---
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters advanced by EN, with registered
// Hsync, Vsync, DE, position and line/frame markers decoded from the next raster position.
module vga_timing_gen #(
  parameter int unsigned HACT   = 640,
  parameter int unsigned HFP    = 16,
  parameter int unsigned HSW    = 96,
  parameter int unsigned HBP    = 48,
  parameter int unsigned VACT   = 480,
  parameter int unsigned VFP    = 10,
  parameter int unsigned VSW    = 2,
  parameter int unsigned VBP    = 33,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        EN,
  output logic        Hsync,
  output logic        Vsync,
  output logic        DE,
  output logic [11:0] hpos,
  output logic [11:0] vpos,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned HTOT = HACT + HFP + HSW + HBP;
  localparam int unsigned VTOT = VACT + VFP + VSW + VBP;

  generate
    if (HTOT > 4096 || VTOT > 4096 || HTOT == 0 || VTOT == 0) begin : g_bad_geometry
      $error("vga_timing_gen: HTOT and VTOT must lie within 1..4096");
    end
  endgenerate

  localparam logic [11:0] H_LAST = 12'(HTOT - 1);
  localparam logic [11:0] V_LAST = 12'(VTOT - 1);

  // Window bounds are 13 bits so an end bound of exactly 4096 still compares correctly.
  localparam logic [12:0] H_ACT  = 13'(HACT);
  localparam logic [12:0] HS_BEG = 13'(HACT + HFP);
  localparam logic [12:0] HS_END = 13'(HACT + HFP + HSW);
  localparam logic [12:0] V_ACT  = 13'(VACT);
  localparam logic [12:0] VS_BEG = 13'(VACT + VFP);
  localparam logic [12:0] VS_END = 13'(VACT + VFP + VSW);

  logic [11:0] hc;
  logic [11:0] vc;
  logic [11:0] h_next;
  logic [11:0] v_next;
  logic        de_next;
  logic        hs_next;
  logic        vs_next;
  logic        line_next;
  logic        frame_next;

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    h_next = hc;
    v_next = vc;
    if (EN) begin
      if (hc == H_LAST) begin
        h_next = '0;
        v_next = (vc == V_LAST) ? '0 : vc + 12'd1;
      end else begin
        h_next = hc + 12'd1;
      end
    end
  end

  // Decode from the position the counters are about to enter, so registered
  // outputs line up with hpos/vpos on the same edge.
  always_comb begin
    de_next    = ({1'b0, h_next} < H_ACT) && ({1'b0, v_next} < V_ACT);
    hs_next    = (({1'b0, h_next} >= HS_BEG) && ({1'b0, h_next} < HS_END)) ? HS_POL : ~HS_POL;
    vs_next    = (({1'b0, v_next} >= VS_BEG) && ({1'b0, v_next} < VS_END)) ? VS_POL : ~VS_POL;
    line_next  = EN && (h_next == '0);
    frame_next = line_next && (v_next == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hc          <= H_LAST;
      vc          <= V_LAST;
      Hsync       <= ~HS_POL;
      Vsync       <= ~VS_POL;
      DE          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hc          <= h_next;
      vc          <= v_next;
      line_start  <= line_next;
      frame_start <= frame_next;
      if (EN) begin
        Hsync <= hs_next;
        Vsync <= vs_next;
        DE    <= de_next;
      end
    end
  end

  assign hpos = hc;
  assign vpos = vc;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640x480 default instance and a tiny 16x7 instance with
// inverted sync polarity, checked per cycle through a scoreboard plus windowed counts.
module tb_vga_timing_gen;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        EN;

  logic        b_hs, b_vs, b_de, b_ls, b_fs;
  logic [11:0] b_h, b_v;
  logic        s_hs, s_vs, s_de, s_ls, s_fs;
  logic [11:0] s_h, s_v;

  always #5 CLK = ~CLK;

  vga_timing_gen dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN),
    .Hsync(b_hs), .Vsync(b_vs), .DE(b_de), .hpos(b_h), .vpos(b_v),
    .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .HACT(8), .HFP(2), .HSW(3), .HBP(3), .VACT(4), .VFP(1), .VSW(1), .VBP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .CLK(CLK), .RESET_N(RESET_N), .EN(EN),
    .Hsync(s_hs), .Vsync(s_vs), .DE(s_de), .hpos(s_h), .vpos(s_v),
    .line_start(s_ls), .frame_start(s_fs)
  );

  typedef struct {
    int   h;
    int   v;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t b;
    exp_t s;
  } item_t;

  item_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cycle = 0;
  int    n     = 0;   // enabled edges since the last reset release

  always @(posedge CLK) cycle <= cycle + 1;

  // Expected outputs after `cnt` enabled edges; position taken directly from the edge count.
  function automatic exp_t model(input int cnt, input bit adv,
                                 input int ha, input int hfp, input int hsw, input int hbp,
                                 input int va, input int vfp, input int vsw, input int vbp,
                                 input bit hp, input bit vp);
    exp_t e;
    int   ht;
    int   vt;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    if (cnt == 0) begin
      e.h = ht - 1;
      e.v = vt - 1;
    end else begin
      e.h = (cnt - 1) % ht;
      e.v = ((cnt - 1) / ht) % vt;
    end
    e.de = (cnt != 0) && (e.h < ha) && (e.v < va);
    e.hs = (e.h >= ha + hfp && e.h < ha + hfp + hsw) ? hp : !hp;
    e.vs = (e.v >= va + vfp && e.v < va + vfp + vsw) ? vp : !vp;
    e.ls = adv && (cnt != 0) && (e.h == 0);
    e.fs = e.ls && (e.v == 0);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_one(input string tag, input int cyc, input exp_t e,
                         input logic [11:0] h, input logic [11:0] v, input logic de,
                         input logic hs, input logic vs, input logic ls, input logic fs);
    n_cmp++;
    if (h !== 12'(e.h) || v !== 12'(e.v) || de !== e.de || hs !== e.hs ||
        vs !== e.vs || ls !== e.ls || fs !== e.fs) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b, expected h=%0d v=%0d de=%b hs=%b vs=%b ls=%b fs=%b",
               tag, cyc, h, v, de, hs, vs, ls, fs, e.h, e.v, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  // Drive one cycle of EN and queue the response expected after the coming edge.
  task automatic step(input bit en);
    item_t it;
    int    nn;
    EN     = en;
    nn     = (RESET_N && en) ? n + 1 : n;
    it.cyc = cycle + 1;
    it.b   = model(nn, en, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    it.s   = model(nn, en, 8, 2, 3, 3, 4, 1, 1, 1, 1'b1, 1'b1);
    sb.push_back(it);
    n = nn;
    @(negedge CLK);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge CLK);
      #1;
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
        it = sb.pop_front();
        if (it.cyc < cycle) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stale_item: expected at cycle %0d, seen at cycle %0d", it.cyc, cycle);
        end else begin
          cmp_one("big", it.cyc, it.b, b_h, b_v, b_de, b_hs, b_vs, b_ls, b_fs);
          cmp_one("small", it.cyc, it.s, s_h, s_v, s_de, s_hs, s_vs, s_ls, s_fs);
        end
      end
    end
  end

  // Free-running event counters; windows are measured as differences of snapshots.
  int de_b = 0, hsl_b = 0, ls_b = 0, fs_b = 0;
  int de_s = 0, hsh_s = 0, vsh_s = 0, fs_s = 0;
  int first_hs_h = -1;
  int fs_s_last = -1, fs_s_gap = -1;
  int ls_t[$];

  always @(negedge CLK) begin
    if (b_de === 1'b1) de_b <= de_b + 1;
    if (b_hs === 1'b0) hsl_b <= hsl_b + 1;
    if (b_ls === 1'b1) begin
      ls_b <= ls_b + 1;
      ls_t.push_back(cycle);
    end
    if (b_fs === 1'b1) fs_b <= fs_b + 1;
    if (b_hs === 1'b0 && first_hs_h < 0) first_hs_h <= int'(b_h);
    if (s_de === 1'b1) de_s <= de_s + 1;
    if (s_hs === 1'b1) hsh_s <= hsh_s + 1;
    if (s_vs === 1'b1) vsh_s <= vsh_s + 1;
    if (s_fs === 1'b1) begin
      fs_s <= fs_s + 1;
      if (fs_s_last >= 0) fs_s_gap <= cycle - fs_s_last;
      fs_s_last <= cycle;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int p_de_b, p_hsl_b, p_ls_b, p_fs_b, p_de_s, p_hsh_s, p_vsh_s, p_fs_s;
    int gap1, gap2, gap3;

    RESET_N = 1'b0;
    EN      = 1'b0;
    repeat (3) @(negedge CLK);
    #2;
    check("rst_b_de", b_de, 0);
    check("rst_b_hsync", b_hs, 1);
    check("rst_b_vsync", b_vs, 1);
    check("rst_b_hpos", b_h, 799);
    check("rst_b_vpos", b_v, 524);
    check("rst_b_line_start", b_ls, 0);
    check("rst_b_frame_start", b_fs, 0);
    check("rst_s_hsync", s_hs, 0);
    check("rst_s_vsync", s_vs, 0);
    check("rst_s_hpos", s_h, 15);
    check("rst_s_vpos", s_v, 6);

    @(negedge CLK);
    RESET_N = 1'b1;
    step(1'b0);
    #2;

    // One full default line with EN held high.
    p_de_b = de_b; p_hsl_b = hsl_b; p_ls_b = ls_b; p_fs_b = fs_b;
    p_de_s = de_s; p_hsh_s = hsh_s; p_vsh_s = vsh_s; p_fs_s = fs_s;
    repeat (800) step(1'b1);
    #2;
    check("line_de_cycles", de_b - p_de_b, 640);
    check("line_hsync_low_cycles", hsl_b - p_hsl_b, 96);
    check("line_hsync_first_h", first_hs_h, 656);
    check("line_start_count", ls_b - p_ls_b, 1);
    check("frame_start_count", fs_b - p_fs_b, 1);
    check("small_de_cycles", de_s - p_de_s, 232);
    check("small_hsync_high_cycles", hsh_s - p_hsh_s, 150);
    check("small_vsync_high_cycles", vsh_s - p_vsh_s, 112);
    check("small_frame_start_count", fs_s - p_fs_s, 8);
    check("small_frame_period", fs_s_gap, 112);

    // One default line with EN alternating 1/0.
    p_de_b = de_b; p_hsl_b = hsl_b; p_ls_b = ls_b;
    repeat (800) begin
      step(1'b1);
      step(1'b0);
    end
    #2;
    check("toggle_de_cycles", de_b - p_de_b, 1280);
    check("toggle_hsync_low_cycles", hsl_b - p_hsl_b, 192);
    check("toggle_line_start_width", ls_b - p_ls_b, 1);

    // Run on to (h=300, v=3) for the mid-frame reset.
    while (n < 2701) step(1'b1);
    #2;
    check("pre_rst_hpos", b_h, 300);
    check("pre_rst_vpos", b_v, 3);
    check("line_start_pulses", ls_t.size(), 4);
    gap1 = (ls_t.size() >= 4) ? ls_t[1] - ls_t[0] : -1;
    gap2 = (ls_t.size() >= 4) ? ls_t[2] - ls_t[1] : -1;
    gap3 = (ls_t.size() >= 4) ? ls_t[3] - ls_t[2] : -1;
    check("line_period_en_high", gap1, 800);
    check("line_period_en_toggle", gap2, 1600);
    check("line_period_en_high_again", gap3, 800);

    RESET_N = 1'b0;
    #1;
    check("async_rst_b_de", b_de, 0);
    check("async_rst_b_hsync", b_hs, 1);
    check("async_rst_b_vsync", b_vs, 1);
    check("async_rst_b_hpos", b_h, 799);
    check("async_rst_b_vpos", b_v, 524);
    check("async_rst_s_hpos", s_h, 15);
    check("async_rst_s_vpos", s_v, 6);

    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    n = 0;
    step(1'b1);
    #2;
    check("restart_hpos", b_h, 0);
    check("restart_vpos", b_v, 0);
    check("restart_frame_start", b_fs, 1);
    check("restart_line_start", b_ls, 1);
    check("restart_s_frame_start", s_fs, 1);
    repeat (300) step(1'b1);
    step(1'b0);
    step(1'b0);

    repeat (3) @(negedge CLK);
    #2;
    check("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
